// File: rtl/ex_mac_seq_pkg.sv
// ex_mac_seq_pkg
//   Shared definitions for the EX-stage multiply-accumulate sequencer:
//   bus widths, ALU opcodes acted on by the sequencer, stall/write-enable
//   levels, the sequencer state encoding and small opcode decode helpers.
package ex_mac_seq_pkg;

    localparam int REG_BUS_W    = 32;
    localparam int ALU_OP_BUS_W = 8;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [ALU_OP_BUS_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALU_OP_BUS_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALU_OP_BUS_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [ALU_OP_BUS_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALU_OP_BUS_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    typedef enum logic {
        MAC_IDLE = 1'b0,
        MAC_ACC  = 1'b1
    } mac_state_e;

    // True for any of the four multiply-accumulate opcodes.
    function automatic logic is_mac_op(input logic [ALU_OP_BUS_W-1:0] op);
        case (op)
            EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: is_mac_op = 1'b1;
            default:                                              is_mac_op = 1'b0;
        endcase
    endfunction

    // True when the product must be formed with two's-complement operands.
    function automatic logic is_signed_mac_op(input logic [ALU_OP_BUS_W-1:0] op);
        case (op)
            EXE_MADD_OP, EXE_MSUB_OP: is_signed_mac_op = 1'b1;
            default:                  is_signed_mac_op = 1'b0;
        endcase
    endfunction

    // True when the product is subtracted from HI/LO rather than added.
    function automatic logic is_sub_mac_op(input logic [ALU_OP_BUS_W-1:0] op);
        case (op)
            EXE_MSUB_OP, EXE_MSUBU_OP: is_sub_mac_op = 1'b1;
            default:                   is_sub_mac_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mac_seq_mul_signed_unsigned.sv
// mul_signed_unsigned
//   Combinational DATA_W x DATA_W -> 2*DATA_W multiplier. With signed_sel
//   high the operands are two's complement: negative operands are negated,
//   magnitudes multiplied, and the result negated when the signs differ.
//   With signed_sel low the operands are zero-extended.
// Ports:
//   a, b       multiplicand / multiplier
//   signed_sel 1 = signed product, 0 = unsigned product
//   product    full-width product
module mul_signed_unsigned #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                signed_sel,
    output logic [2*DATA_W-1:0] product
);

    localparam logic [DATA_W-1:0]   ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W = {{(2*DATA_W-1){1'b0}}, 1'b1};

    logic                a_neg_s;
    logic                b_neg_s;
    logic [DATA_W-1:0]   a_mag_s;
    logic [DATA_W-1:0]   b_mag_s;
    logic [2*DATA_W-1:0] mag_prod_s;

    // Sign/magnitude multiply; 0x80.. negates to itself and is still the
    // correct unsigned magnitude.
    always_comb begin
        a_neg_s    = signed_sel & a[DATA_W-1];
        b_neg_s    = signed_sel & b[DATA_W-1];
        a_mag_s    = a_neg_s ? (~a + ONE_W) : a;
        b_mag_s    = b_neg_s ? (~b + ONE_W) : b;
        mag_prod_s = {{DATA_W{1'b0}}, a_mag_s} * {{DATA_W{1'b0}}, b_mag_s};
        if (a_neg_s ^ b_neg_s) begin
            product = ~mag_prod_s + ONE_2W;
        end else begin
            product = mag_prod_s;
        end
    end

endmodule

// File: rtl/ex_mac_seq.sv
// ex_mac_seq
//   Two-cycle multiply-accumulate sequencer for the EX stage (MADD, MADDU,
//   MSUB, MSUBU). The first EX cycle registers rs*rt and requests a stall so
//   the instruction is held; the second adds/subtracts the registered product
//   to/from the forwarded HI/LO pair and raises the HI/LO write enable.
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-high reset
//   aluop_i           decoded ALU operation
//   reg1_i, reg2_i    forwarded rs / rt operands
//   hi_i, lo_i        forwarded current HI / LO
//   stall_i           EX held by a later-stage stall
//   flush_i           pipeline flush
//   stall_req_o       stall request for EX and earlier stages
//   whilo_o           HI/LO write enable
//   hi_o, lo_o        HI/LO write-back value
//   busy_o            accumulate cycle in progress
module ex_mac_seq
    import ex_mac_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [ALU_OP_BUS_W-1:0] aluop_i,
    input  logic [DATA_W-1:0]       reg1_i,
    input  logic [DATA_W-1:0]       reg2_i,
    input  logic [DATA_W-1:0]       hi_i,
    input  logic [DATA_W-1:0]       lo_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    stall_req_o,
    output logic                    whilo_o,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    busy_o
);

    localparam logic [2*DATA_W-1:0] ONE_2W = {{(2*DATA_W-1){1'b0}}, 1'b1};

    mac_state_e          state_r;
    mac_state_e          state_nxt_s;
    logic [2*DATA_W-1:0] hilo_temp_r;
    logic [2*DATA_W-1:0] product_s;
    logic [2*DATA_W-1:0] addend_s;
    logic [2*DATA_W-1:0] acc_sum_s;
    logic                mac_s;
    logic                capture_s;

    assign mac_s = is_mac_op(aluop_i);

    mul_signed_unsigned #(
        .DATA_W (DATA_W)
    ) u_mul (
        .a          (reg1_i),
        .b          (reg2_i),
        .signed_sel (is_signed_mac_op(aluop_i)),
        .product    (product_s)
    );

    // Accumulate the registered product into the live forwarded HI/LO.
    always_comb begin
        if (is_sub_mac_op(aluop_i)) begin
            addend_s = ~hilo_temp_r + ONE_2W;
        end else begin
            addend_s = hilo_temp_r;
        end
        acc_sum_s = {hi_i, lo_i} + addend_s;
    end

    // Next-state and output decode; outputs are all forced low under reset.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        stall_req_o = NO_STOP;
        whilo_o     = WRITE_DISABLE;
        hi_o        = {DATA_W{1'b0}};
        lo_o        = {DATA_W{1'b0}};
        busy_o      = 1'b0;
        case (state_r)
            MAC_IDLE: begin
                if (mac_s) begin
                    stall_req_o = STOP;
                    // Operands are held by our own stall, so a later-stage
                    // stall does not prevent capturing the product.
                    capture_s   = 1'b1;
                    if (flush_i) begin
                        state_nxt_s = MAC_IDLE;
                    end else begin
                        state_nxt_s = MAC_ACC;
                    end
                end else begin
                    state_nxt_s = MAC_IDLE;
                end
            end
            MAC_ACC: begin
                busy_o = 1'b1;
                whilo_o = flush_i ? WRITE_DISABLE : WRITE_ENABLE;
                {hi_o, lo_o} = acc_sum_s;
                if (flush_i || !stall_i) begin
                    state_nxt_s = MAC_IDLE;
                end else begin
                    state_nxt_s = MAC_ACC;
                end
            end
            default: begin
                state_nxt_s = MAC_IDLE;
            end
        endcase
        if (Rst) begin
            stall_req_o = NO_STOP;
            whilo_o     = WRITE_DISABLE;
            hi_o        = {DATA_W{1'b0}};
            lo_o        = {DATA_W{1'b0}};
            busy_o      = 1'b0;
        end else begin
            busy_o = (state_r == MAC_ACC);
        end
    end

    // State and product registers; the product only loads from IDLE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r     <= MAC_IDLE;
            hilo_temp_r <= {(2*DATA_W){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                hilo_temp_r <= product_s;
            end
        end
    end

endmodule

// File: tb/tb_ex_mac_seq.sv
module tb_ex_mac_seq;
    import ex_mac_seq_pkg::*;

    localparam int DW = 32;

    logic                    Clk;
    logic                    Rst;
    logic [ALU_OP_BUS_W-1:0] aluop_i;
    logic [DW-1:0]           reg1_i;
    logic [DW-1:0]           reg2_i;
    logic [DW-1:0]           hi_i;
    logic [DW-1:0]           lo_i;
    logic                    stall_i;
    logic                    flush_i;
    logic                    stall_req_o;
    logic                    whilo_o;
    logic [DW-1:0]           hi_o;
    logic [DW-1:0]           lo_o;
    logic                    busy_o;

    int total = 0;
    int bad   = 0;

    ex_mac_seq #(.DATA_W(DW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .aluop_i     (aluop_i),
        .reg1_i      (reg1_i),
        .reg2_i      (reg2_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .busy_o      (busy_o)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic s, input logic w, input logic b);
        chk1({tag, ".stall"}, stall_req_o, s);
        chk1({tag, ".whilo"}, whilo_o, w);
        chk1({tag, ".busy"}, busy_o, b);
    endtask

    task automatic res(input string tag, input logic [DW-1:0] h, input logic [DW-1:0] l);
        chk({tag, ".hi"}, hi_o, h);
        chk({tag, ".lo"}, lo_o, l);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_op(input logic [ALU_OP_BUS_W-1:0] op, input logic [DW-1:0] r1,
                          input logic [DW-1:0] r2, input logic [DW-1:0] h, input logic [DW-1:0] l);
        aluop_i = op;
        reg1_i  = r1;
        reg2_i  = r2;
        hi_i    = h;
        lo_i    = l;
    endtask

    initial begin
        Rst = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        set_op(EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd0);
        next_cycle;
        next_cycle;
        #1;
        // Reset: outputs low even with a MAC opcode presented
        ctl("rst", 1'b0, 1'b0, 1'b0);
        res("rst", 32'h0, 32'h0);
        next_cycle;
        Rst = 1'b0;
        set_op(EXE_NOP_OP, 32'd0, 32'd0, 32'd0, 32'd0);
        #1;
        ctl("nop", 1'b0, 1'b0, 1'b0);

        // 1: MADD 3 * -2 + 0xA = 4
        next_cycle;
        set_op(EXE_MADD_OP, 32'd3, 32'hFFFF_FFFE, 32'h0, 32'hA);
        #1;
        ctl("t1.c0", 1'b1, 1'b0, 1'b0);
        res("t1.c0", 32'h0, 32'h0);
        next_cycle;
        #1;
        ctl("t1.c1", 1'b0, 1'b1, 1'b1);
        res("t1.c1", 32'h0, 32'h4);
        next_cycle;
        aluop_i = EXE_NOP_OP;
        #1;
        ctl("t1.c2", 1'b0, 1'b0, 1'b0);
        res("t1.c2", 32'h0, 32'h0);

        // 2: MADDU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        next_cycle;
        set_op(EXE_MADDU_OP, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
        next_cycle;
        #1;
        res("t2", 32'h1, 32'hFFFF_FFFE);

        // 3: MSUB 0 - 35, then back-to-back MSUBU 0x1_00000000 - 0x1_00000000
        next_cycle;
        set_op(EXE_MSUB_OP, 32'd5, 32'd7, 32'h0, 32'h0);
        #1;
        ctl("t3a.c0", 1'b1, 1'b0, 1'b0);
        next_cycle;
        #1;
        res("t3a", 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        next_cycle;
        set_op(EXE_MSUBU_OP, 32'h8000_0000, 32'd2, 32'h1, 32'h0);
        #1;
        ctl("t3b.c0", 1'b1, 1'b0, 1'b0);
        next_cycle;
        #1;
        ctl("t3b.c1", 1'b0, 1'b1, 1'b1);
        res("t3b", 32'h0, 32'h0);

        // Signed negative * negative: -3 * -4 = 12
        next_cycle;
        set_op(EXE_MADD_OP, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 32'h0);
        next_cycle;
        #1;
        res("negneg", 32'h0, 32'hC);

        // 4: late forwarding then stall held in ACC
        next_cycle;
        set_op(EXE_MADD_OP, 32'd2, 32'd2, 32'h0, 32'h0);
        next_cycle;
        #1;
        res("t4.fwd0", 32'h0, 32'h4);
        lo_i = 32'h1;
        stall_i = 1'b1;
        #1;
        res("t4.fwd1", 32'h0, 32'h5);
        next_cycle;
        #1;
        ctl("t4.st1", 1'b0, 1'b1, 1'b1);
        res("t4.st1", 32'h0, 32'h5);
        next_cycle;
        #1;
        ctl("t4.st2", 1'b0, 1'b1, 1'b1);
        res("t4.st2", 32'h0, 32'h5);
        stall_i = 1'b0;
        next_cycle;
        aluop_i = EXE_NOP_OP;
        #1;
        ctl("t4.idle", 1'b0, 1'b0, 1'b0);

        // 5a: flush in the IDLE cycle aborts the MAC
        next_cycle;
        set_op(EXE_MADD_OP, 32'd2, 32'd3, 32'h0, 32'h0);
        flush_i = 1'b1;
        #1;
        ctl("t5a.c0", 1'b1, 1'b0, 1'b0);
        next_cycle;
        flush_i = 1'b0;
        aluop_i = EXE_NOP_OP;
        #1;
        ctl("t5a.c1", 1'b0, 1'b0, 1'b0);

        // 5b: flush in the ACC cycle suppresses the write
        next_cycle;
        set_op(EXE_MADD_OP, 32'd2, 32'd3, 32'h0, 32'h0);
        next_cycle;
        flush_i = 1'b1;
        #1;
        chk1("t5b.whilo", whilo_o, 1'b0);
        next_cycle;
        flush_i = 1'b0;
        aluop_i = EXE_NOP_OP;
        #1;
        ctl("t5b.c2", 1'b0, 1'b0, 1'b0);

        // 5c: Rst mid-ACC drops outputs before the next edge
        next_cycle;
        set_op(EXE_MADD_OP, 32'd2, 32'd3, 32'h0, 32'h0);
        next_cycle;
        #1;
        ctl("t5c.acc", 1'b0, 1'b1, 1'b1);
        Rst = 1'b1;
        #1;
        ctl("t5c.rst", 1'b0, 1'b0, 1'b0);
        res("t5c.rst", 32'h0, 32'h0);
        next_cycle;
        Rst = 1'b0;
        aluop_i = EXE_NOP_OP;

        // 6: two back-to-back MADDU
        next_cycle;
        set_op(EXE_MADDU_OP, 32'd2, 32'd3, 32'h0, 32'h0);
        #1;
        chk1("t6.s0", stall_req_o, 1'b1);
        next_cycle;
        #1;
        chk1("t6.s1", stall_req_o, 1'b0);
        res("t6a", 32'h0, 32'd6);
        next_cycle;
        set_op(EXE_MADDU_OP, 32'd4, 32'd5, 32'h0, 32'd6);
        #1;
        chk1("t6.s2", stall_req_o, 1'b1);
        next_cycle;
        #1;
        chk1("t6.s3", stall_req_o, 1'b0);
        res("t6b", 32'h0, 32'd26);

        next_cycle;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
